// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM controller: valid/ready request channel, byte enables,
// post-reset clear, range check and a 2-entry read-response FIFO. Option: RAM_PARITY_EN.
module ram_ctrl #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int CLR_INIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = (CLR_INIT != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_err;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_init_busy;

  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_err;
  logic [0:0]        w_state_nxt;
  logic [1:0]        w_occ_nxt;
  logic              w_rd_ptr_nxt;
  logic [DATA_W-1:0] w_head_data_nxt;
  logic              w_head_err_nxt;

  assign w_in_range = ({1'b0, req_addr} < DEPTH_V);
  assign w_idx      = w_in_range ? req_addr : '0;
  assign w_acc      = req_valid & r_req_ready;
  assign w_rd_acc   = w_acc & ~req_we;
  assign w_wr_acc   = w_acc & req_we & w_in_range;
  assign w_pop      = r_rsp_valid & rsp_ready;
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

`ifdef RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_wpar;
  logic          w_par_err;

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  assign w_wpar    = byte_parity(req_wdata);
  assign w_par_err = |(byte_parity(r_mem[w_idx]) ^ r_par[w_idx]);
  assign w_rd_err  = ~w_in_range | w_par_err;

  // Parity store: cleared alongside data, updated per enabled byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_par[r_clr_ptr] <= '0;
      end else if (w_wr_acc) begin
        for (int i = 0; i < NB; i++) begin
          if (req_be[i]) r_par[w_idx][i] <= w_wpar[i];
        end
      end
    end
  end
`else
  assign w_rd_err = ~w_in_range;
`endif

  // Next-state, occupancy and next FIFO head; head may be the entry written this cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_clr_ptr == LAST_ADDR) w_state_nxt = ST_RUN;
        else                        w_state_nxt = ST_INIT;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RESET;
    endcase

    case ({w_rd_acc, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase

    w_rd_ptr_nxt = w_pop ? ~r_rd_ptr : r_rd_ptr;

    w_head_data_nxt = '0;
    w_head_err_nxt  = 1'b0;
    if (w_occ_nxt == 2'd0) begin
      w_head_data_nxt = '0;
      w_head_err_nxt  = 1'b0;
    end else if (w_rd_acc && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_data_nxt = w_rd_data;
      w_head_err_nxt  = w_rd_err;
    end else begin
      w_head_data_nxt = r_fifo_data[w_rd_ptr_nxt];
      w_head_err_nxt  = r_fifo_err[w_rd_ptr_nxt];
    end
  end

  // Control state, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_clr_ptr   <= '0;
      r_occ       <= 2'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_init_busy <= (CLR_INIT != 0);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
      r_occ    <= w_occ_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_rd_acc) r_wr_ptr <= ~r_wr_ptr;
      // Ready follows registered occupancy, so a pop never frees a slot in the same cycle
      r_req_ready <= (w_state_nxt == ST_RUN) && (w_occ_nxt != 2'd2);
      r_rsp_valid <= (w_occ_nxt != 2'd0);
      r_rsp_rdata <= w_head_data_nxt;
      r_rsp_err   <= w_head_err_nxt;
      r_init_busy <= (w_state_nxt == ST_INIT);
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (!reset && w_rd_acc) begin
      r_fifo_data[r_wr_ptr] <= w_rd_data;
      r_fifo_err[r_wr_ptr]  <= w_rd_err;
    end
  end

  // Memory array: zero fill during INIT, byte-enabled writes in RUN; untouched while in reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_acc) begin
        for (int i = 0; i < NB; i++) begin
          if (req_be[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign init_busy = r_init_busy;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: scoreboard of expected read responses plus directed steps.
// A second instance with DEPTH=200 covers the out-of-range path.
module tb_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, init_busy;
  logic [15:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [7:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic [1:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_init_busy;
  logic [15:0] b_rsp_rdata;

  ram_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(8), .CLR_INIT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_busy(init_busy)
  );

  ram_ctrl #(.DATA_W(16), .DEPTH(200), .ADDR_W(8), .CLR_INIT(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .init_busy(b_init_busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  logic [15:0] m_mem [256];
  int          flip_addr = -1;
  bit          mon_en = 1'b0;
  logic [16:0] mon_e;
  logic [16:0] hold_prev;
  bit          hold_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_e[15:0]});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e[16]});
        end
      end else if (rsp_valid === 1'b1) begin
        if (hold_v) chk("rsp_hold_stable", {15'd0, rsp_err, rsp_rdata}, {15'd0, hold_prev});
        hold_prev = {rsp_err, rsp_rdata};
        hold_v = 1'b1;
      end else begin
        hold_v = 1'b0;
        chk("idle_zero", {15'd0, rsp_err, rsp_rdata}, 32'd0);
      end
    end
  end

  task automatic model_clear();
    foreach (m_mem[i]) m_mem[i] = 16'h0000;
  endtask

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                        input logic [1:0] be);
    bit acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) acc = 1'b1;
    end
    if (acc) begin
      if (we) begin
        if (be[0]) m_mem[addr][7:0]  = wd[7:0];
        if (be[1]) m_mem[addr][15:8] = wd[15:8];
      end else begin
        exp_q.push_back({(int'(addr) == flip_addr), m_mem[addr]});
      end
    end else begin
      chk("req_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic b_req(input logic we, input logic [7:0] addr, input logic [15:0] wd);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_be = 2'b11;
    @(negedge clk);
    chk("b_req_ready", {31'd0, b_req_ready}, 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_clear();
  endtask

  task automatic count_busy(output int n);
    bit done = 1'b0;
    n = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (init_busy === 1'b1) n++;
      else done = 1'b1;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000; req_be = 2'b00;
    rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 8'h00; b_req_wdata = 16'h0000;
    b_req_be = 2'b00; b_rsp_ready = 1'b1;
    model_clear();

    @(posedge clk); #1;
    chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_out", {15'd0, rsp_err, rsp_rdata}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    count_busy(n);
    chk("clear_cycles", n, 32'd256);
    chk("ready_after_clear", {31'd0, req_ready}, 32'd1);

    do_req(1'b0, 8'h7F, 16'h0000, 2'b00);
    do_req(1'b1, 8'h10, 16'hABCD, 2'b11);
    do_req(1'b1, 8'h10, 16'h12EE, 2'b10);
    do_req(1'b0, 8'h10, 16'h0000, 2'b00);
    do_req(1'b1, 8'h10, 16'h5A5A, 2'b00);
    do_req(1'b0, 8'h10, 16'h0000, 2'b00);
    do_req(1'b1, 8'hFF, 16'hBEEF, 2'b11);
    do_req(1'b1, 8'h00, 16'h0102, 2'b01);
    do_req(1'b0, 8'hFF, 16'h0000, 2'b00);
    do_req(1'b0, 8'h00, 16'h0000, 2'b00);
    wait_drain();

    // Back-pressure: two reads fill the FIFO, third waits for the first pop
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h10, 16'h0000, 2'b00);
    do_req(1'b0, 8'hFF, 16'h0000, 2'b00);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
    @(negedge clk);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_still_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("bp_third_accept", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, m_mem[0]});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain();

    // Out-of-range on the DEPTH=200 instance
    b_req(1'b1, 8'd0, 16'h1234);
    b_req(1'b1, 8'd200, 16'h5555);
    b_req(1'b0, 8'd200, 16'h0000);
    @(negedge clk);
    chk("range_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("range_rdata", {16'd0, b_rsp_rdata}, 32'd0);
    chk("range_err", {31'd0, b_rsp_err}, 32'd1);
    b_req(1'b0, 8'd0, 16'h0000);
    @(negedge clk);
    chk("range_word0", {15'd0, b_rsp_err, b_rsp_rdata}, 32'h1234);
    b_req(1'b0, 8'd199, 16'h0000);
    @(negedge clk);
    chk("range_last_ok", {14'd0, b_rsp_valid, b_rsp_err, b_rsp_rdata}, 32'h20000);

    // Reset with a response pending drops it
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h10, 16'h0000, 2'b00);
    do_reset();
    chk("drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("drop_init_busy", {31'd0, init_busy}, 32'd1);
    rsp_ready = 1'b1;

    for (int k = 0; k < 100; k++) @(negedge clk);
    do_reset();
    count_busy(n);
    chk("midclear_cycles", n, 32'd256);
    chk("midclear_ready", {31'd0, req_ready}, 32'd1);
    chk("midclear_fifo_empty", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 8'h10, 16'h0000, 2'b00);
    do_req(1'b0, 8'hFF, 16'h0000, 2'b00);
    wait_drain();

`ifdef RAM_PARITY_EN
    do_req(1'b1, 8'h20, 16'h0F0F, 2'b11);
    @(posedge clk); #1;
    dut.r_mem[32] = dut.r_mem[32] ^ 16'h0001;
    m_mem[32] = 16'h0F0E;
    flip_addr = 32;
    do_req(1'b0, 8'h20, 16'h0000, 2'b00);
    wait_drain();
    flip_addr = -1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
